// File: rtl/otter_fetch_stage.sv
// Instruction-fetch front end for the pipelined OTTER core: owns the PC, drives the
// synchronous-read IMEM and buffers up to two fetched words ahead of IF/ID.
module otter_fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_IR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_rden,
    input  logic [31:0] imem_dout,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    input  logic [31:0] trap_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_ir
);

    logic [31:0] pc_q;
    logic [31:0] infl_pc_q;
    logic        infl_q;
    logic [31:0] buf_pc_q [2];
    logic [31:0] buf_ir_q [2];
    logic        head_q;
    logic        tail_q;
    logic [1:0]  cnt_q;

    logic        flush;
    logic        pop;
    logic        push;
    logic        issue;
    logic [31:0] target;
    logic [2:0]  occ;

    always_comb begin
        flush       = trap | redirect;
        target      = trap ? trap_pc : redirect_pc;
        target[1:0] = 2'b00;
        if_valid    = (cnt_q != 2'd0);
        pop         = if_valid & ~stall & ~flush;
        // Entries that will occupy the buffer next cycle if nothing new is requested.
        occ         = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
        issue       = ~flush & (occ < 3'd2);
        push        = infl_q & ~flush;
        if_pc       = if_valid ? buf_pc_q[head_q] : 32'h0;
        if_ir       = if_valid ? buf_ir_q[head_q] : NOP_IR;
    end

    assign imem_addr = pc_q;
    assign imem_rden = issue & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_VEC;
            infl_q    <= 1'b0;
            infl_pc_q <= 32'h0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            cnt_q     <= 2'd0;
        end else if (flush) begin
            pc_q   <= target;
            infl_q <= 1'b0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (issue) begin
                pc_q      <= pc_q + 32'd4;
                infl_q    <= 1'b1;
                infl_pc_q <= pc_q;
            end else begin
                infl_q <= 1'b0;
            end
            if (push) tail_q <= ~tail_q;
            if (pop)  head_q <= ~head_q;
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload storage needs no reset: cnt_q alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[tail_q] <= infl_pc_q;
            buf_ir_q[tail_q] <= imem_dout;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && push && !pop) begin
            assert (cnt_q != 2'd2)
            else $error("fetch buffer overflow: push into full buffer");
        end
    end
`endif

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Self-checking bench for otter_fetch_stage: directed scenarios then randomized traffic,
// checked against a sequence-level model (program order + fixed post-flush latency).
module tb_otter_fetch_stage;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] NOP_IR    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rden;
    logic [31:0] imem_dout = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        trap = 1'b0;
    logic [31:0] trap_pc = 32'h0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_ir;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: the next instruction expected in program order, and cycles since the last flush.
    logic [31:0] exp_pc;
    int          k;

    otter_fetch_stage #(
        .RESET_VEC(RESET_VEC),
        .NOP_IR   (NOP_IR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_rden  (imem_rden),
        .imem_dout  (imem_dout),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .trap       (trap),
        .trap_pc    (trap_pc),
        .stall      (stall),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_ir      (if_ir)
    );

    always #5 clk = ~clk;

    // Synchronous-read IMEM whose contents are address + 0x100.
    always @(posedge clk) begin
        if (imem_rden) imem_dout <= imem_addr + 32'h100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive just after posedge, check at negedge, advance the model.
    task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic tr, input logic [31:0] tpc, input int rden_exp);
        logic fl;
        logic vexp;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        trap        = tr;
        trap_pc     = tpc;
        fl          = tr | rd;
        vexp        = (k >= 3);
        @(negedge clk);
        chk("if_valid", {31'b0, if_valid}, {31'b0, vexp});
        if (vexp) begin
            chk("if_pc", if_pc, exp_pc);
            chk("if_ir", if_ir, exp_pc + 32'h100);
        end else begin
            chk("if_pc_empty", if_pc, 32'h0);
            chk("if_ir_empty", if_ir, NOP_IR);
        end
        if (fl) begin
            chk("rden_flush", {31'b0, imem_rden}, 32'h0);
        end else if (k == 1) begin
            chk("rden_restart", {31'b0, imem_rden}, 32'h1);
            chk("addr_restart", imem_addr, exp_pc);
        end
        if (rden_exp >= 0) chk("rden_directed", {31'b0, imem_rden}, rden_exp[31:0]);
        if (fl) begin
            k      = 1;
            exp_pc = (tr ? tpc : rpc) & 32'hFFFF_FFFC;
        end else begin
            if (vexp && !st) exp_pc = exp_pc + 32'd4;
            if (k < 3) k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic st);
        for (int i = 0; i < n; i++) cyc(st, 1'b0, 32'h0, 1'b0, 32'h0, -1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
        chk({tag, "_pc"}, if_pc, 32'h0);
        chk({tag, "_ir"}, if_ir, NOP_IR);
        chk({tag, "_addr"}, imem_addr, RESET_VEC);
        chk({tag, "_rden"}, {31'b0, imem_rden}, 32'h0);
    endtask

    initial begin
        k      = 1;
        exp_pc = RESET_VEC;

        // Reset held: outputs at their idle values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stream from reset; valid appears 2 cycles after release.
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1);
        run(7, 1'b0);

        // Stall 4 cycles: head held, IMEM requests stop once the buffer is full.
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, -1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, -1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1);
        run(5, 1'b0);

        // Branch redirect to 0x200.
        cyc(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 0);
        run(6, 1'b0);

        // Trap and redirect together while stalled with a full buffer: trap target wins.
        run(2, 1'b1);
        cyc(1'b1, 1'b1, 32'h200, 1'b1, 32'h80, 0);
        run(3, 1'b1);
        run(4, 1'b0);

        // Misaligned target is forced to a word boundary.
        cyc(1'b0, 1'b1, 32'h203, 1'b0, 32'h0, 0);
        run(5, 1'b0);

        // PC wraps from 0xFFFF_FFFC to 0.
        cyc(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 0);
        run(6, 1'b0);

        // Fill the buffer, release for one cycle so a request is in flight, then reset.
        run(3, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        k      = 1;
        exp_pc = RESET_VEC;
        run(6, 1'b0);

        // Randomized stalls, redirects and traps with arbitrary (possibly misaligned) targets.
        for (int i = 0; i < 1500; i++) begin
            logic st;
            logic rd;
            logic tr;
            st = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 15) == 0);
            tr = ($urandom_range(0, 31) == 0);
            cyc(st, rd, $urandom, tr, $urandom, -1);
        end
        run(4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
